// File: rtl/rram_ctrl_wv.sv
// RRAM word controller: read and write-verify sequencing with bounded re-program retries.
// Strobes, enables and status are registered and line up with the FSM state they belong to.
module rram_ctrl_wv #(
  parameter int unsigned B_SIZE    = 4,
  parameter int unsigned X_SIZE    = 3,
  parameter int unsigned Y_SIZE    = 5,
  parameter int unsigned PRE_CYC   = 2,
  parameter int unsigned DVLP_CYC  = 2,
  parameter int unsigned SA_CYC    = 1,
  parameter int unsigned WR_CYC    = 4,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     EN,
  input  logic                     RW,
  input  logic [X_SIZE-1:0]        X_ADDRESS_IN,
  input  logic [Y_SIZE-1:0]        Y_ADDRESS_IN,
  input  logic [B_SIZE-1:0]        DIN,
  input  logic [B_SIZE-1:0]        SA_OUT,
  output logic [(1<<X_SIZE):0]     P_EN,
  output logic [(1<<X_SIZE):0]     P_NOT_EN,
  output logic [(1<<X_SIZE)-1:0]   N_EN,
  output logic [(1<<X_SIZE)-1:0]   N_NOT_EN,
  output logic [(1<<Y_SIZE)-1:0]   SEL,
  output logic                     READ,
  output logic                     WRITE,
  output logic                     WRITE_2,
  output logic                     NOT_WRITE,
  output logic                     NOT_WRITE_2,
  output logic                     PRE,
  output logic                     DVLP,
  output logic                     EN_SA,
  output logic [B_SIZE-1:0]        WMASK,
  output logic [B_SIZE-1:0]        DOUT,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     FAIL
);

  localparam int unsigned NX      = 1 << X_SIZE;
  localparam int unsigned NY      = 1 << Y_SIZE;
  localparam int unsigned MAX_AB  = (PRE_CYC > DVLP_CYC) ? PRE_CYC : DVLP_CYC;
  localparam int unsigned MAX_CD  = (SA_CYC > WR_CYC) ? SA_CYC : WR_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_PRE, S_DVLP, S_SENSE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_last;
  logic [RTY_W-1:0]    retry_q, retry_d;
  logic [X_SIZE-1:0]   x_q, x_d;
  logic [Y_SIZE-1:0]   y_q, y_d;
  logic                rw_q, rw_d;
  logic [B_SIZE-1:0]   din_q, din_d;
  logic [B_SIZE-1:0]   mask_q, mask_d;
  logic [B_SIZE-1:0]   dout_d, wmask_d;
  logic                fail_d, busy_d, done_d;
  logic                write_d, pre_d, dvlp_d, ensa_d, read_d;
  logic [NX:0]         p_en_d;
  logic [NX-1:0]       n_en_d, x_oh;
  logic [NY-1:0]       sel_d;
  logic                phase_end;

  // Terminal count of the shared phase counter for the current phase
  always_comb begin
    cnt_last = '0;
    case (state_q)
      S_WRITE: cnt_last = CNT_W'(WR_CYC - 1);
      S_PRE:   cnt_last = CNT_W'(PRE_CYC - 1);
      S_DVLP:  cnt_last = CNT_W'(DVLP_CYC - 1);
      S_SENSE: cnt_last = CNT_W'(SA_CYC - 1);
      default: cnt_last = '0;
    endcase
  end

  assign phase_end = (cnt_q == cnt_last);

  // Next state, captured request and registered-output next values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    x_d     = x_q;
    y_d     = y_q;
    rw_d    = rw_q;
    din_d   = din_q;
    mask_d  = mask_q;
    fail_d  = FAIL;
    dout_d  = DOUT;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (EN) begin
          x_d     = X_ADDRESS_IN;
          y_d     = Y_ADDRESS_IN;
          rw_d    = RW;
          din_d   = DIN;
          mask_d  = DIN;
          retry_d = '0;
          fail_d  = 1'b0;
          state_d = RW ? S_WRITE : S_PRE;
        end
      end
      S_WRITE: if (phase_end) begin state_d = S_PRE;   cnt_d = '0; end
      S_PRE:   if (phase_end) begin state_d = S_DVLP;  cnt_d = '0; end
      S_DVLP:  if (phase_end) begin state_d = S_SENSE; cnt_d = '0; end
      S_SENSE: begin
        if (phase_end) begin
          cnt_d  = '0;
          dout_d = SA_OUT;
          if (!rw_q || (SA_OUT == din_q)) begin
            state_d = S_DONE;
          end else if (retry_q == RTY_W'(MAX_RETRY)) begin
            state_d = S_DONE;
            fail_d  = 1'b1;
          end else begin
            // Re-program only the set bits that did not verify
            state_d = S_WRITE;
            retry_d = retry_q + RTY_W'(1);
            mask_d  = din_q & (SA_OUT ^ din_q);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    x_oh    = NX'(1) << x_d;
    write_d = (state_d == S_WRITE);
    pre_d   = (state_d == S_PRE);
    dvlp_d  = (state_d == S_DVLP);
    ensa_d  = (state_d == S_SENSE);
    read_d  = pre_d || dvlp_d || ensa_d;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    sel_d   = (write_d || read_d) ? (NY'(1) << y_d) : '0;
    p_en_d  = read_d ? {1'b1, x_oh} : '0;
    n_en_d  = write_d ? x_oh : '0;
    wmask_d = write_d ? mask_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      rw_q        <= 1'b0;
      din_q       <= '0;
      mask_q      <= '0;
      P_EN        <= '0;
      P_NOT_EN    <= '1;
      N_EN        <= '0;
      N_NOT_EN    <= '1;
      SEL         <= '0;
      READ        <= 1'b0;
      WRITE       <= 1'b0;
      WRITE_2     <= 1'b0;
      NOT_WRITE   <= 1'b1;
      NOT_WRITE_2 <= 1'b1;
      PRE         <= 1'b0;
      DVLP        <= 1'b0;
      EN_SA       <= 1'b0;
      WMASK       <= '0;
      DOUT        <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      FAIL        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rw_q        <= rw_d;
      din_q       <= din_d;
      mask_q      <= mask_d;
      P_EN        <= p_en_d;
      P_NOT_EN    <= ~p_en_d;
      N_EN        <= n_en_d;
      N_NOT_EN    <= ~n_en_d;
      SEL         <= sel_d;
      READ        <= read_d;
      WRITE       <= write_d;
      WRITE_2     <= write_d;
      NOT_WRITE   <= ~write_d;
      NOT_WRITE_2 <= ~write_d;
      PRE         <= pre_d;
      DVLP        <= dvlp_d;
      EN_SA       <= ensa_d;
      WMASK       <= wmask_d;
      DOUT        <= dout_d;
      BUSY        <= busy_d;
      DONE        <= done_d;
      FAIL        <= fail_d;
    end
  end

endmodule

// File: tb/tb_rram_ctrl_wv.sv
// Bench for rram_ctrl_wv: per-transaction cycle timeline built from the phase rules, random traffic.
module tb_rram_ctrl_wv;

  localparam int unsigned B  = 4;
  localparam int unsigned XS = 3;
  localparam int unsigned YS = 5;
  localparam int unsigned NX = 1 << XS;
  localparam int unsigned NY = 1 << YS;
  localparam int unsigned PC = 2;
  localparam int unsigned DC = 2;
  localparam int unsigned SC = 1;
  localparam int unsigned WC = 4;
  localparam int unsigned MR = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0, rw = 1'b0;
  logic [XS-1:0] xa = '0;
  logic [YS-1:0] ya = '0;
  logic [B-1:0]  din = '0, sa = '0;
  logic [NX:0]   p_en, p_not_en;
  logic [NX-1:0] n_en, n_not_en;
  logic [NY-1:0] sel;
  logic read, write, write_2, not_write, not_write_2, pre, dvlp, en_sa;
  logic [B-1:0]  wmask, dout;
  logic busy, done, fail;

  rram_ctrl_wv #(
    .B_SIZE(B), .X_SIZE(XS), .Y_SIZE(YS), .PRE_CYC(PC), .DVLP_CYC(DC),
    .SA_CYC(SC), .WR_CYC(WC), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset(reset), .EN(en), .RW(rw),
    .X_ADDRESS_IN(xa), .Y_ADDRESS_IN(ya), .DIN(din), .SA_OUT(sa),
    .P_EN(p_en), .P_NOT_EN(p_not_en), .N_EN(n_en), .N_NOT_EN(n_not_en),
    .SEL(sel), .READ(read), .WRITE(write), .WRITE_2(write_2),
    .NOT_WRITE(not_write), .NOT_WRITE_2(not_write_2), .PRE(pre), .DVLP(dvlp),
    .EN_SA(en_sa), .WMASK(wmask), .DOUT(dout), .BUSY(busy), .DONE(done), .FAIL(fail)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Phase codes: 0 idle, 1 write, 2 pre, 3 develop, 4 sense, 5 done
  typedef struct {
    int          ph;
    logic [B-1:0] mask;
    logic [B-1:0] sa;
    logic [B-1:0] dout;
    logic        fail;
  } cyc_t;

  cyc_t tl[$];
  logic [B-1:0] m_dout = '0;
  logic         m_fail = 1'b0;

  task automatic push(input int ph, input logic [B-1:0] mask, input logic [B-1:0] s);
    cyc_t c;
    c.ph = ph; c.mask = mask; c.sa = s; c.dout = m_dout; c.fail = m_fail;
    tl.push_back(c);
  endtask

  task automatic build(input logic w, input logic [B-1:0] d, input logic [B-1:0] sa_att [MR+1]);
    logic [B-1:0] mask;
    logic ok;
    int a;
    tl.delete();
    m_fail = 1'b0;
    mask = d;
    a = 0;
    forever begin
      if (w) repeat (WC) push(1, mask, B'($urandom));
      repeat (PC) push(2, '0, B'($urandom));
      repeat (DC) push(3, '0, B'($urandom));
      for (int s = 0; s < int'(SC); s++)
        push(4, '0, (s == int'(SC) - 1) ? sa_att[a] : B'($urandom));
      m_dout = sa_att[a];
      ok = !w || (sa_att[a] == d);
      if (ok || a == int'(MR)) begin
        m_fail = !ok;
        push(5, '0, B'($urandom));
        break;
      end
      mask = d & (sa_att[a] ^ d);
      a++;
    end
  endtask

  task automatic check_cycle(input string tag, input int ph, input int x, input int y,
                             input logic [B-1:0] mask, input logic [B-1:0] edout, input logic efail);
    logic [63:0] one = 64'd1;
    logic [63:0] ep, en_x, es;
    logic rd, wr;
    rd   = (ph >= 2 && ph <= 4);
    wr   = (ph == 1);
    ep   = rd ? ((one << NX) | (one << x)) : 64'd0;
    en_x = wr ? (one << x) : 64'd0;
    es   = (rd || wr) ? (one << y) : 64'd0;
    check_eq({tag, ".strobes"},
             {54'd0, busy, done, read, write, write_2, pre, dvlp, en_sa, not_write, not_write_2},
             {54'd0, ph != 0, ph == 5, rd, wr, wr, ph == 2, ph == 3, ph == 4, !wr, !wr});
    check_eq({tag, ".sel"}, 64'(sel), es);
    check_eq({tag, ".p_en"}, 64'(p_en), ep);
    check_eq({tag, ".p_not_en"}, 64'(p_not_en), ~ep & ((one << (NX + 1)) - 1));
    check_eq({tag, ".n_en"}, 64'(n_en), en_x);
    check_eq({tag, ".n_not_en"}, 64'(n_not_en), ~en_x & ((one << NX) - 1));
    check_eq({tag, ".wmask"}, 64'(wmask), wr ? 64'(mask) : 64'd0);
    check_eq({tag, ".dout"}, 64'(dout), 64'(edout));
    check_eq({tag, ".fail"}, 64'(fail), 64'(efail));
  endtask

  // One request from IDLE; abort_at>0 asserts reset during that cycle number after acceptance
  task automatic run_txn(input string tag, input logic w, input int x, input int y,
                         input logic [B-1:0] d, input logic [B-1:0] sa_att [MR+1],
                         input int abort_at);
    build(w, d, sa_att);
    en = 1'b1; rw = w; xa = XS'(x); ya = YS'(y); din = d; sa = B'($urandom);
    for (int i = 0; i < tl.size(); i++) begin
      @(posedge clk); #1;
      check_cycle(tag, tl[i].ph, x, y, tl[i].mask, tl[i].dout, tl[i].fail);
      sa = tl[i].sa;
      en = 1'($urandom); rw = 1'($urandom);
      xa = XS'($urandom); ya = YS'($urandom); din = B'($urandom);
      if (abort_at == i + 1) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; en = 1'b0;
        m_dout = '0; m_fail = 1'b0;
        check_cycle({tag, ".rst"}, 0, 0, 0, '0, '0, 1'b0);
        return;
      end
    end
    @(posedge clk); #1;
    en = 1'b0;
    check_cycle({tag, ".idle"}, 0, 0, 0, '0, m_dout, m_fail);
  endtask

  logic [B-1:0] att [MR+1];
  logic w;
  logic [B-1:0] d;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_cycle("reset", 0, 0, 0, '0, '0, 1'b0);

    att = '{4'hA, 4'h0, 4'h0, 4'h0};
    run_txn("read_x5_y17", 1'b0, 5, 17, 4'h0, att, 0);
    att = '{4'h6, 4'h0, 4'h0, 4'h0};
    run_txn("write_pass", 1'b1, 5, 17, 4'h6, att, 0);
    att = '{4'h7, 4'hF, 4'h0, 4'h0};
    run_txn("write_retry", 1'b1, 2, 9, 4'hF, att, 0);
    att = '{4'h0, 4'h0, 4'h0, 4'h0};
    run_txn("write_exhaust", 1'b1, 7, 31, 4'h3, att, 0);
    att = '{4'h5, 4'h0, 4'h0, 4'h0};
    run_txn("write_reset", 1'b1, 1, 4, 4'h5, att, 3);
    att = '{4'h9, 4'h0, 4'h0, 4'h0};
    run_txn("after_reset", 1'b0, 3, 0, 4'h0, att, 0);

    for (int t = 0; t < 200; t++) begin
      w = 1'($urandom);
      d = B'($urandom);
      for (int a = 0; a <= int'(MR); a++)
        att[a] = ($urandom_range(0, 2) == 0) ? d : B'($urandom);
      run_txn("rand", w, int'($urandom_range(0, NX - 1)), int'($urandom_range(0, NY - 1)), d, att,
              ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 8)) : 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check_cycle("rand.gap", 0, 0, 0, '0, m_dout, m_fail);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rram_ctrl_wv.md
RRAM_CTRL_WV -- requirements
Module: rram_ctrl_wv

Interface
REQ-001 SHALL have parameter B_SIZE, default 4, word width in bits.
REQ-002 SHALL have parameter X_SIZE, default 3, word-column address bits (2^X_SIZE word columns).
REQ-003 SHALL have parameter Y_SIZE, default 5, row address bits (2^Y_SIZE rows).
REQ-004 SHALL have parameters PRE_CYC=2, DVLP_CYC=2, SA_CYC=1, WR_CYC=4, each >=1, giving phase lengths in clk cycles.
REQ-005 SHALL have parameter MAX_RETRY, default 3, the maximum number of re-program pulses after the first write.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 EN  in  1  request strobe, sampled only in IDLE.
REQ-010 RW  in  1  1=write-verify, 0=read.
REQ-011 X_ADDRESS_IN  in  X_SIZE  word-column address.
REQ-012 Y_ADDRESS_IN  in  Y_SIZE  row address.
REQ-013 DIN  in  B_SIZE  write data.
REQ-014 SA_OUT  in  B_SIZE  sense-amplifier result, valid in the last SENSE cycle.
REQ-015 P_EN, P_NOT_EN  out  2^X_SIZE+1  read column enables; MSB is the reference column; P_NOT_EN = ~P_EN.
REQ-016 N_EN, N_NOT_EN  out  2^X_SIZE  write column enables; N_NOT_EN = ~N_EN.
REQ-017 SEL  out  2^Y_SIZE  one-hot row select.
REQ-018 READ, WRITE, WRITE_2, NOT_WRITE, NOT_WRITE_2, PRE, DVLP, EN_SA  out  1  phase strobes; WRITE_2=WRITE; NOT_WRITE=NOT_WRITE_2=~WRITE.
REQ-019 WMASK  out  B_SIZE  bits to be programmed during WRITE.
REQ-020 DOUT  out  B_SIZE  registered read/verify data.
REQ-021 BUSY, DONE, FAIL  out  1  status.

Function
REQ-022 SHALL implement FSM states IDLE, WRITE, PRE, DVLP, SENSE, CHECK_DONE (DONE).
REQ-023 In IDLE with EN=1, SHALL capture X, Y, RW, and DIN, clear the retry count, and go to WRITE if RW=1, else PRE.
REQ-024 WRITE, PRE, DVLP, and SENSE SHALL each last exactly WR_CYC, PRE_CYC, DVLP_CYC, and SA_CYC cycles, using one shared phase counter.
REQ-025 Transitions: WRITE->PRE; PRE->DVLP; DVLP->SENSE; SENSE->DONE (read); SENSE->DONE (write, SA_OUT==captured DIN); SENSE->DONE with FAIL=1 (write, mismatch, retry==MAX_RETRY); SENSE->WRITE with retry+1 (write, mismatch, retry<MAX_RETRY); DONE->IDLE.
REQ-026 DOUT SHALL load SA_OUT on the last SENSE cycle and hold until the next SENSE.
REQ-027 DONE SHALL be a one-cycle pulse; FAIL SHALL be valid with DONE and hold until the next accepted request.
REQ-028 BUSY SHALL be 1 in every state except IDLE.
REQ-029 SEL SHALL be the one-hot decode of the captured Y in all non-IDLE, non-DONE states, and all-zero otherwise.
REQ-030 During PRE, DVLP, and SENSE, P_EN SHALL be the one-hot decode of the captured X with the MSB (reference) set to 1; otherwise it SHALL be zero.
REQ-031 N_EN SHALL be the one-hot decode of the captured X only in WRITE; otherwise it SHALL be zero.
REQ-032 Strobes: WRITE=1 in WRITE; PRE=1 in PRE; DVLP=1 in DVLP; EN_SA=1 in SENSE; READ=1 in PRE, DVLP, and SENSE.
REQ-033 WMASK SHALL equal the captured DIN on the first pulse, equal the captured DIN AND (SA_OUT XOR DIN) from the failing SENSE on each retry, and be zero outside WRITE.
REQ-034 EN while BUSY SHALL be ignored (not queued); address and data changes while BUSY SHALL have no effect.
REQ-035 The retry counter SHALL be sized clog2(MAX_RETRY+1) and SHALL saturate at MAX_RETRY; MAX_RETRY=0 means a single pulse.

Reset
REQ-036 reset=1 at a clock edge SHALL force IDLE from any state, including mid-phase.
REQ-037 Reset SHALL zero all enables, strobes, WMASK, DOUT, BUSY, DONE, FAIL, the counters, and the captured registers; P_NOT_EN and N_NOT_EN SHALL be all-ones; NOT_WRITE and NOT_WRITE_2 SHALL be 1.

Verification
REQ-038 Read: EN=1, RW=0, X=5, Y=17, SA_OUT=4'hA -> PRE in cycles 1-2, DVLP in cycles 3-4, EN_SA in cycle 5, DONE in cycle 6, DOUT=4'hA, SEL[17]=1, P_EN=9'h120.
REQ-039 Write, first-pass: RW=1, DIN=4'h6, SA_OUT=4'h6 -> WRITE in cycles 1-4, WMASK=4'h6, N_EN[5]=1, DONE in cycle 10, FAIL=0.
REQ-040 Write, retry: DIN=4'hF, SA_OUT=4'h7 then 4'hF -> second WRITE with WMASK=4'h8, DONE in cycle 19, FAIL=0.
REQ-041 Write, exhausted: SA_OUT is always 4'h0 with DIN=4'h3 -> 4 WRITE pulses, DONE with FAIL=1.
REQ-042 reset asserted in cycle 3 of WRITE -> next cycle IDLE, all REQ-037 values; a new EN in the following cycle is accepted.
REQ-043 EN pulsed during BUSY with a different address -> ignored, SEL unchanged, single DONE.
